// File: rtl/micro_port_rx.sv
// micro_port_rx: receiver for the 8-bit microcontroller write port.
// Synchronises the asynchronous micro strobes, decodes address/data bytes
// into a shadow register bank and commits that bank to reg_out at frame start.
module micro_port_rx #(
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [7:0]            fpga_port_in,
  input  logic                  fpga_rsel,
  input  logic                  fpga_write,
  input  logic                  frame_start,
  output logic [NUM_REGS*8-1:0] reg_out,
  output logic [ADDR_W-1:0]     addr_ptr,
  output logic                  write_ack,
  output logic                  commit,
  output logic                  addr_err
);

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  logic [DATA_W-1:0]      port_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] rsel_sync;
  logic [SYNC_STAGES-1:0] write_sync;

  logic                   ws;
  logic                   rsel_s;
  logic [DATA_W-1:0]      data_s;

  state_t                 state;
  logic [DATA_W-1:0]      cap_data;
  logic                   cap_rsel;
  logic                   dirty;
  logic [DATA_W-1:0]      shadow [NUM_REGS];

  assign ws     = write_sync[SYNC_STAGES-1];
  assign rsel_s = rsel_sync[SYNC_STAGES-1];
  assign data_s = port_sync[SYNC_STAGES-1];

  // Multi-stage synchronisers on every micro input.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        port_sync[i] <= '0;
      end
      rsel_sync  <= '0;
      write_sync <= '0;
    end else begin
      port_sync[0] <= fpga_port_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        port_sync[i] <= port_sync[i-1];
      end
      rsel_sync  <= {rsel_sync[SYNC_STAGES-2:0], fpga_rsel};
      write_sync <= {write_sync[SYNC_STAGES-2:0], fpga_write};
    end
  end

  // Strobe FSM, byte decode into the shadow bank, and frame-start commit.
  // The data-byte dirty set is written after the commit clear so a byte
  // captured in the commit cycle stays pending for the next frame.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      cap_data  <= '0;
      cap_rsel  <= 1'b0;
      addr_ptr  <= '0;
      write_ack <= 1'b0;
      commit    <= 1'b0;
      addr_err  <= 1'b0;
      dirty     <= 1'b0;
      reg_out   <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        shadow[i] <= '0;
      end
    end else begin
      write_ack <= 1'b0;
      commit    <= 1'b0;

      if (frame_start && dirty) begin
        for (int i = 0; i < int'(NUM_REGS); i++) begin
          reg_out[8*i +: 8] <= shadow[i];
        end
        dirty  <= 1'b0;
        commit <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (ws) begin
            cap_data <= data_s;
            cap_rsel <= rsel_s;
            state    <= CAPTURE;
          end
        end
        CAPTURE: begin
          write_ack <= 1'b1;
          state     <= WAIT_LOW;
          if (cap_rsel) begin
            shadow[addr_ptr] <= cap_data;
            addr_ptr         <= addr_ptr + ADDR_W'(1);
            dirty            <= 1'b1;
          end else begin
            addr_ptr <= cap_data[ADDR_W-1:0];
            if ({1'b0, cap_data} >= 9'(NUM_REGS)) begin
              addr_err <= 1'b1;
            end
          end
        end
        WAIT_LOW: begin
          if (!ws) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_micro_port_rx.sv
// Directed self-checking bench for micro_port_rx.
module tb_micro_port_rx;

  logic         Clk;
  logic         Reset;
  logic [7:0]   fpga_port_in;
  logic         fpga_rsel;
  logic         fpga_write;
  logic         frame_start;
  logic [127:0] reg_out;
  logic [3:0]   addr_ptr;
  logic         write_ack;
  logic         commit;
  logic         addr_err;

  int compared;
  int mismatched;
  int acks;
  int first;
  int commits;

  micro_port_rx #(
    .NUM_REGS    (16),
    .ADDR_W      (4),
    .SYNC_STAGES (2)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .fpga_port_in (fpga_port_in),
    .fpga_rsel    (fpga_rsel),
    .fpga_write   (fpga_write),
    .frame_start  (frame_start),
    .reg_out      (reg_out),
    .addr_ptr     (addr_ptr),
    .write_ack    (write_ack),
    .commit       (commit),
    .addr_err     (addr_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One micro byte transfer; counts write_ack pulses and the negedge index of the first one.
  task automatic write_byte(input logic rs, input logic [7:0] d, input int hold,
                            output int n_ack, output int first_ack);
    n_ack = 0;
    first_ack = 0;
    @(negedge Clk);
    fpga_port_in = d;
    fpga_rsel = rs;
    repeat (4) @(negedge Clk);
    fpga_write = 1'b1;
    for (int k = 1; k <= hold; k++) begin
      @(negedge Clk);
      if (write_ack) begin
        n_ack++;
        if (first_ack == 0) first_ack = k;
      end
    end
    fpga_write = 1'b0;
    repeat (6) begin
      @(negedge Clk);
      if (write_ack) n_ack++;
    end
  endtask

  // One-cycle frame_start pulse; counts commit pulses that follow it.
  task automatic pulse_frame(output int n_commit);
    n_commit = 0;
    @(negedge Clk);
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    if (commit) n_commit++;
    repeat (3) begin
      @(negedge Clk);
      if (commit) n_commit++;
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    Reset = 1'b0;
    fpga_port_in = 8'h00;
    fpga_rsel = 1'b0;
    fpga_write = 1'b0;
    frame_start = 1'b0;

    // Reset state
    #1;
    check("rst_reg_out_lo", reg_out[31:0], 32'h0);
    check("rst_addr_ptr", 32'(addr_ptr), 32'h0);
    check("rst_ack", 32'(write_ack), 32'h0);
    check("rst_commit", 32'(commit), 32'h0);
    check("rst_addr_err", 32'(addr_err), 32'h0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);

    // Address 0x03, data 0xAA, 0x55
    write_byte(1'b0, 8'h03, 6, acks, first);
    check("a03_acks", 32'(acks), 32'd1);
    check("a03_latency", 32'(first), 32'd4);
    check("a03_ptr", 32'(addr_ptr), 32'd3);
    write_byte(1'b1, 8'hAA, 6, acks, first);
    check("dAA_acks", 32'(acks), 32'd1);
    check("dAA_ptr", 32'(addr_ptr), 32'd4);
    write_byte(1'b1, 8'h55, 6, acks, first);
    check("d55_acks", 32'(acks), 32'd1);
    check("d55_ptr", 32'(addr_ptr), 32'd5);
    check("pre_commit_reg3", 32'(reg_out[31:24]), 32'h00);
    pulse_frame(commits);
    check("commit1_pulses", 32'(commits), 32'd1);
    check("commit1_reg3", 32'(reg_out[31:24]), 32'hAA);
    check("commit1_reg4", 32'(reg_out[39:32]), 32'h55);

    // Pointer wrap: address 0x0F, data 0x11, 0x22
    write_byte(1'b0, 8'h0F, 6, acks, first);
    write_byte(1'b1, 8'h11, 6, acks, first);
    write_byte(1'b1, 8'h22, 6, acks, first);
    check("wrap_ptr", 32'(addr_ptr), 32'd1);
    pulse_frame(commits);
    check("commit2_pulses", 32'(commits), 32'd1);
    check("commit2_reg15", 32'(reg_out[127:120]), 32'h11);
    check("commit2_reg0", 32'(reg_out[7:0]), 32'h22);
    check("commit2_reg3", 32'(reg_out[31:24]), 32'hAA);

    // Out-of-range address sets sticky addr_err
    check("pre_addr_err", 32'(addr_err), 32'd0);
    write_byte(1'b0, 8'h20, 6, acks, first);
    check("a20_err", 32'(addr_err), 32'd1);
    check("a20_ptr", 32'(addr_ptr), 32'd0);
    write_byte(1'b0, 8'h02, 6, acks, first);
    check("a02_err_sticky", 32'(addr_err), 32'd1);
    check("a02_ptr", 32'(addr_ptr), 32'd2);

    // Held strobe yields one byte; frame_start without dirty does nothing
    write_byte(1'b0, 8'h05, 50, acks, first);
    check("held_acks", 32'(acks), 32'd1);
    check("held_latency", 32'(first), 32'd4);
    check("held_ptr", 32'(addr_ptr), 32'd5);
    pulse_frame(commits);
    check("clean_commit_pulses", 32'(commits), 32'd0);
    check("clean_reg15", 32'(reg_out[127:120]), 32'h11);
    check("clean_reg2", 32'(reg_out[23:16]), 32'h00);

    // Data byte capture coinciding with frame_start
    write_byte(1'b0, 8'h00, 6, acks, first);
    write_byte(1'b1, 8'h99, 6, acks, first);
    write_byte(1'b0, 8'h02, 6, acks, first);
    @(negedge Clk);
    fpga_port_in = 8'h77;
    fpga_rsel = 1'b1;
    repeat (4) @(negedge Clk);
    fpga_write = 1'b1;
    repeat (3) @(negedge Clk);
    check("coinc_ack_before", 32'(write_ack), 32'd0);
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    check("coinc_ack", 32'(write_ack), 32'd1);
    check("coinc_commit", 32'(commit), 32'd1);
    check("coinc_reg2_old", 32'(reg_out[23:16]), 32'h00);
    check("coinc_reg0", 32'(reg_out[7:0]), 32'h99);
    check("coinc_ptr", 32'(addr_ptr), 32'd3);
    fpga_write = 1'b0;
    repeat (6) @(negedge Clk);
    pulse_frame(commits);
    check("coinc_next_pulses", 32'(commits), 32'd1);
    check("coinc_next_reg2", 32'(reg_out[23:16]), 32'h77);

    // Reset mid-transfer (FSM in WAIT_LOW, addr_ptr=5)
    @(negedge Clk);
    fpga_port_in = 8'h05;
    fpga_rsel = 1'b0;
    repeat (4) @(negedge Clk);
    fpga_write = 1'b1;
    repeat (8) @(negedge Clk);
    check("mid_ptr", 32'(addr_ptr), 32'd5);
    Reset = 1'b0;
    #1;
    check("mid_rst_ptr", 32'(addr_ptr), 32'd0);
    check("mid_rst_reg2", 32'(reg_out[23:16]), 32'h00);
    check("mid_rst_reg15", 32'(reg_out[127:120]), 32'h00);
    check("mid_rst_err", 32'(addr_err), 32'd0);
    check("mid_rst_ack", 32'(write_ack), 32'd0);
    check("mid_rst_commit", 32'(commit), 32'd0);
    fpga_write = 1'b0;
    repeat (4) @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    write_byte(1'b1, 8'h44, 6, acks, first);
    check("post_rst_acks", 32'(acks), 32'd1);
    check("post_rst_latency", 32'(first), 32'd4);
    check("post_rst_ptr", 32'(addr_ptr), 32'd1);
    pulse_frame(commits);
    check("post_rst_commits", 32'(commits), 32'd1);
    check("post_rst_reg0", 32'(reg_out[7:0]), 32'h44);
    check("post_rst_reg3", 32'(reg_out[31:24]), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
